// File: rtl/bfnp_pkg.sv
// bfnp_pkg: shared types and constants for the BFNP update scheduler.
//   sched_state_t  : scheduler FSM states (INIT sweep, IDLE, ISSUE)
//   upd_entry_t    : queued training request {index, dir}
//   sum_magnitude  : |sum| widened by one bit so -2^(W-1) stays positive
package bfnp_pkg;

   localparam int BFNP_IDX_W         = 10;
   localparam int BFNP_SUM_W         = 9;
   localparam int BFNP_THETA_DEFAULT = 45;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      ISSUE
   } sched_state_t;

   typedef struct packed {
      logic [BFNP_IDX_W-1:0] index;
      logic                  dir;
   } upd_entry_t;

   function automatic logic [BFNP_SUM_W:0] sum_magnitude(input logic [BFNP_SUM_W-1:0] sum);
      logic [BFNP_SUM_W:0] ext;
      ext = {sum[BFNP_SUM_W-1], sum};
      return ext[BFNP_SUM_W] ? ('0 - ext) : ext;
   endfunction

endpackage

// File: rtl/bfnp_update_scheduler_if.sv
// bfnp_update_scheduler_if: training-request handshake and table-write bus.
//   req_valid/req_index/req_dir/req_mispred/req_sum -> scheduler, req_ready <- scheduler
//   upd_en/upd_index/upd_dir/upd_clear <- scheduler (write strobe to the tables)
//   master: request producer / table side; slave: the scheduler.
interface bfnp_update_scheduler_if;
   import bfnp_pkg::*;

   logic                         req_valid;
   logic [BFNP_IDX_W-1:0]        req_index;
   logic                         req_dir;
   logic                         req_mispred;
   logic signed [BFNP_SUM_W-1:0] req_sum;
   logic                         req_ready;

   logic                         upd_en;
   logic [BFNP_IDX_W-1:0]        upd_index;
   logic                         upd_dir;
   logic                         upd_clear;

   modport master (
      output req_valid, req_index, req_dir, req_mispred, req_sum,
      input  req_ready,
      input  upd_en, upd_index, upd_dir, upd_clear
   );

   modport slave (
      input  req_valid, req_index, req_dir, req_mispred, req_sum,
      output req_ready,
      output upd_en, upd_index, upd_dir, upd_clear
   );

endinterface

// File: rtl/bfnp_upd_fifo.sv
// bfnp_upd_fifo: DEPTH-entry FIFO of training requests.
//   clk, rst (async active-low), push/din, pop/dout (head, valid when !empty),
//   full, empty, count (registered occupancy).
module bfnp_upd_fifo import bfnp_pkg::*; #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  upd_entry_t             din,
   output upd_entry_t             dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   upd_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bfnp_update_scheduler.sv
// bfnp_update_scheduler: schedules training writes to the bias/perceptron/BF tables.
//   clk, rst (async active-low), stall, pred_read (prediction owns the table port),
//   bus (slave): request handshake in, table write strobe out,
//   init_busy, fifo_count, train_count (saturating count of training writes).
// After reset the tables are cleared by a sweep of TBL_ENTRIES zeroing writes.
// Optional: `define BFNP_THRESHOLD_TRAIN_EN also trains correct predictions
// whose |sum| <= THETA; otherwise only mispredictions train.
module bfnp_update_scheduler import bfnp_pkg::*; #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned THETA       = BFNP_THETA_DEFAULT,
   parameter int unsigned TBL_ENTRIES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      pred_read,
   bfnp_update_scheduler_if.slave    bus,
   output logic                      init_busy,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [15:0]               train_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   sched_state_t          state;
   sched_state_t          state_nxt;
   logic [BFNP_IDX_W-1:0] sweep_idx;
   logic                  sweep_last;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  accept;
   logic                  qualify;
   logic                  push;
   logic                  pop;
   upd_entry_t            head;
   upd_entry_t            entry_in;

   assign sweep_last    = (sweep_idx == BFNP_IDX_W'(TBL_ENTRIES - 1));
   assign init_busy     = (state == INIT);
   // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
   assign bus.req_ready = (state != INIT) && !fifo_full;
   assign accept        = bus.req_valid && bus.req_ready && !stall;

`ifdef BFNP_THRESHOLD_TRAIN_EN
   // Magnitude is one bit wider than the sum so -256 reads as 256 and never passes.
   assign qualify = bus.req_mispred || (32'(sum_magnitude(bus.req_sum)) <= THETA);
`else
   logic unused_sum;
   assign unused_sum = ^bus.req_sum;
   assign qualify    = bus.req_mispred;
`endif

   assign push     = accept && qualify;
   assign pop      = (state == ISSUE) && !stall && !pred_read && !fifo_empty;
   assign entry_in = '{index: bus.req_index, dir: bus.req_dir};

   bfnp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (entry_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= INIT;
         sweep_idx   <= '0;
         train_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT) sweep_idx <= sweep_last ? '0 : sweep_idx + BFNP_IDX_W'(1);
         if (pop && (train_count != '1)) train_count <= train_count + 16'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (sweep_last) state_nxt = IDLE;
         IDLE:    if (!fifo_empty) state_nxt = ISSUE;
         ISSUE:   if (pop && (fifo_count == CNT_W'(1)) && !push) state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   // Strobe is qualified by rst so nothing is written while reset is held.
   always_comb begin
      bus.upd_en    = 1'b0;
      bus.upd_clear = 1'b0;
      bus.upd_index = '0;
      bus.upd_dir   = 1'b0;
      if (rst) begin
         if (state == INIT) begin
            bus.upd_en    = 1'b1;
            bus.upd_clear = 1'b1;
            bus.upd_index = sweep_idx;
         end else if (pop) begin
            bus.upd_en    = 1'b1;
            bus.upd_index = head.index;
            bus.upd_dir   = head.dir;
         end
      end
   end

endmodule

// File: tb/tb_bfnp_update_scheduler.sv
// Self-checking bench for bfnp_update_scheduler against a queue-based reference model.
module tb_bfnp_update_scheduler;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned THETA = 45;
   localparam int unsigned TBL   = 1024;
`ifdef BFNP_THRESHOLD_TRAIN_EN
   localparam bit THR_EN = 1'b1;
`else
   localparam bit THR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        pred_read = 1'b0;
   logic        init_busy;
   logic [2:0]  fifo_count;
   logic [15:0] train_count;

   bfnp_update_scheduler_if ifc();

   bfnp_update_scheduler #(.DEPTH(DEPTH), .THETA(THETA), .TBL_ENTRIES(TBL)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .pred_read   (pred_read),
      .bus         (ifc),
      .init_busy   (init_busy),
      .fifo_count  (fifo_count),
      .train_count (train_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model: a queue of pending writes plus the init sweep position.
   typedef struct {
      logic [9:0] idx;
      logic       dir;
   } ment_t;

   ment_t       q[$];
   bit          m_init;
   int unsigned m_sweep;
   bit          m_prev_ne;
   int unsigned m_train;
   bit          m_issue;
   logic [33:0] exp_v;

   function automatic bit model_qualifies(input logic mis, input logic [8:0] sum);
      int s;
      s = int'($signed(sum));
      if (s < 0) s = -s;
      return mis || (THR_EN && (s <= int'(THETA)));
   endfunction

   function automatic logic [33:0] obs_vec();
      return {ifc.upd_en, ifc.upd_clear,
              ifc.upd_en ? ifc.upd_index : 10'd0,
              ifc.upd_en ? ifc.upd_dir : 1'b0,
              init_busy, ifc.req_ready, fifo_count, train_count};
   endfunction

   task automatic model_reset();
      q.delete();
      m_init    = 1'b1;
      m_sweep   = 0;
      m_prev_ne = 1'b0;
      m_train   = 0;
   endtask

   // Issue is possible once the queue has been non-empty across a whole cycle boundary.
   task automatic model_expect();
      logic       en, cl, dr, busy, rdy;
      logic [9:0] ix;
      m_issue = !m_init && m_prev_ne && (q.size() > 0) && !stall && !pred_read;
      if (m_init) begin
         en = 1'b1; cl = 1'b1; ix = 10'(m_sweep); dr = 1'b0; busy = 1'b1; rdy = 1'b0;
      end else begin
         en = m_issue; cl = 1'b0; ix = 10'd0; dr = 1'b0; busy = 1'b0;
         rdy = (q.size() < DEPTH);
         if (m_issue) begin
            ix = q[0].idx;
            dr = q[0].dir;
         end
      end
      exp_v = {en, cl, ix, dr, busy, rdy, 3'(q.size()), 16'(m_train)};
   endtask

   task automatic advance();
      int unsigned start;
      bit          acc;
      @(posedge clk);
      start = q.size();
      acc = !m_init && ifc.req_valid && (start < DEPTH) && !stall;
      if (m_issue) begin
         void'(q.pop_front());
         if (m_train < 65535) m_train++;
      end
      if (acc && model_qualifies(ifc.req_mispred, ifc.req_sum))
         q.push_back('{idx: ifc.req_index, dir: ifc.req_dir});
      if (m_init) begin
         if (m_sweep == TBL - 1) m_init = 1'b0;
         else m_sweep++;
      end
      m_prev_ne = (start > 0);
      cyc++;
      #1;
   endtask

   task automatic set_req(input logic v, input logic [9:0] idx, input logic dir,
                          input logic mis, input logic [8:0] sum);
      ifc.req_valid   = v;
      ifc.req_index   = idx;
      ifc.req_dir     = dir;
      ifc.req_mispred = mis;
      ifc.req_sum     = sum;
   endtask

   task automatic test_reset();
      int n_clear = 0;
      set_req(1'b0, 10'd0, 1'b0, 1'b0, 9'd0);
      rst = 1'b0;
      #3;
      n_checks++;
      if ({ifc.upd_en, ifc.upd_clear, ifc.upd_index, ifc.upd_dir, ifc.req_ready, init_busy, fifo_count, train_count}
          !== {1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0}) begin
         n_errors++;
         $display("FAIL reset_values got en=%b clr=%b idx=%0d dir=%b rdy=%b busy=%b cnt=%0d train=%0d exp 0 0 0 0 0 1 0 0",
                  ifc.upd_en, ifc.upd_clear, ifc.upd_index, ifc.upd_dir, ifc.req_ready, init_busy, fifo_count, train_count);
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 1030; i++) begin
         model_expect();
         #1;
         if (ifc.upd_en === 1'b1 && ifc.upd_clear === 1'b1) n_clear++;
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL sweep cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      n_checks++;
      if (n_clear != 1024 || init_busy !== 1'b0 || ifc.req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL sweep_len got clears=%0d busy=%b rdy=%b exp clears=1024 busy=0 rdy=1",
                  n_clear, init_busy, ifc.req_ready);
      end
   endtask

   task automatic test_single_mispred();
      int first_en = -1;
      for (int k = 0; k < 6; k++) begin
         if (k == 0) set_req(1'b1, 10'h155, 1'b1, 1'b1, 9'($urandom));
         else        set_req(1'b0, 10'd0, 1'b0, 1'b0, 9'd0);
         model_expect();
         #1;
         if (ifc.upd_en === 1'b1 && first_en < 0) first_en = k;
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      n_checks++;
      if (first_en != 2 || train_count !== 16'd1) begin
         n_errors++;
         $display("FAIL single_latency got first=%0d train=%0d exp first=2 train=1", first_en, train_count);
      end
   endtask

   task automatic test_threshold();
      logic [8:0] sums [4];
      int         writes = 0;
      int         exp_writes;
      sums[0] = 9'h1D3;   // -45
      sums[1] = 9'd46;
      sums[2] = 9'h100;   // -256
      sums[3] = 9'd45;
      exp_writes = THR_EN ? 2 : 0;
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 5; k++) begin
            if (k == 0) set_req(1'b1, 10'($urandom), 1'($urandom), 1'b0, sums[s]);
            else        set_req(1'b0, 10'd0, 1'b0, 1'b0, 9'd0);
            model_expect();
            #1;
            if (ifc.upd_en === 1'b1) writes++;
            n_checks++;
            if (obs_vec() !== exp_v) begin
               n_errors++;
               $display("FAIL threshold sum=%h cyc=%0d got=%h exp=%h", sums[s], cyc, obs_vec(), exp_v);
            end
            advance();
         end
      end
      n_checks++;
      if (writes != exp_writes) begin
         n_errors++;
         $display("FAIL threshold_writes got=%0d exp=%0d", writes, exp_writes);
      end
   endtask

   task automatic test_fifo_full();
      logic [9:0] idxs [5];
      logic [9:0] seen [$];
      int         first = -1;
      int         last = -1;
      pred_read = 1'b1;
      for (int k = 0; k < 5; k++) begin
         idxs[k] = 10'($urandom);
         set_req(1'b1, idxs[k], 1'($urandom), 1'b1, 9'd0);
         model_expect();
         #1;
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      set_req(1'b0, 10'd0, 1'b0, 1'b0, 9'd0);
      #1;
      n_checks++;
      if (fifo_count !== 3'd4 || ifc.req_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL full_state got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_count, ifc.req_ready);
      end
      pred_read = 1'b0;
      for (int k = 0; k < 8; k++) begin
         model_expect();
         #1;
         if (ifc.upd_en === 1'b1) begin
            seen.push_back(ifc.upd_index);
            if (first < 0) first = k;
            last = k;
         end
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      n_checks++;
      if (seen.size() != 4 || (last - first) != 3 || ifc.req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL drain_shape got writes=%0d span=%0d rdy=%b exp writes=4 span=3 rdy=1",
                  seen.size(), last - first, ifc.req_ready);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (seen[k] !== idxs[k]) begin
               n_errors++;
               $display("FAIL drain_order k=%0d got=%h exp=%h", k, seen[k], idxs[k]);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [9:0] idxs [2];
      int         offs [$];
      pred_read = 1'b1;
      for (int k = 0; k < 2; k++) begin
         idxs[k] = 10'($urandom);
         set_req(1'b1, idxs[k], 1'($urandom), 1'b1, 9'd0);
         model_expect();
         #1;
         advance();
      end
      set_req(1'b0, 10'd0, 1'b0, 1'b0, 9'd0);
      pred_read = 1'b0;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         model_expect();
         #1;
         n_checks++;
         if (obs_vec() !== exp_v || ifc.upd_en !== 1'b0 || fifo_count !== 3'd2) begin
            n_errors++;
            $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         model_expect();
         #1;
         if (ifc.upd_en === 1'b1) begin
            offs.push_back(k);
            n_checks++;
            if (offs.size() <= 2 && ifc.upd_index !== idxs[offs.size() - 1]) begin
               n_errors++;
               $display("FAIL stall_order got=%h exp=%h", ifc.upd_index, idxs[offs.size() - 1]);
            end
         end
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL stall_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      n_checks++;
      if (offs.size() != 2 || offs[0] != 0 || offs[1] != 1) begin
         n_errors++;
         $display("FAIL stall_b2b got writes=%0d exp writes=2 at offsets 0,1", offs.size());
      end
   endtask

   task automatic test_reset_mid();
      pred_read = 1'b1;
      for (int k = 0; k < 2; k++) begin
         set_req(1'b1, 10'($urandom), 1'($urandom), 1'b1, 9'd0);
         model_expect();
         #1;
         advance();
      end
      set_req(1'b0, 10'd0, 1'b0, 1'b0, 9'd0);
      pred_read = 1'b0;
      rst = 1'b0;
      #2;
      n_checks++;
      if (fifo_count !== 3'd0 || ifc.upd_en !== 1'b0 || init_busy !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_issue got cnt=%0d en=%b busy=%b exp cnt=0 en=0 busy=1", fifo_count, ifc.upd_en, init_busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 300; i++) begin
         model_expect();
         #1;
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL sweep_a cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      n_checks++;
      if (ifc.upd_index !== 10'd300) begin
         n_errors++;
         $display("FAIL sweep_at300 got=%0d exp=300", ifc.upd_index);
      end
      rst = 1'b0;
      #2;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 1030; i++) begin
         model_expect();
         #1;
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL sweep_b cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
   endtask

   task automatic test_random();
      logic [8:0] picks [7];
      logic [8:0] sum;
      picks[0] = 9'd45;   picks[1] = 9'h1D3;  picks[2] = 9'd46;  picks[3] = 9'h1D2;
      picks[4] = 9'h100;  picks[5] = 9'd0;    picks[6] = 9'd255;
      for (int i = 0; i < 600; i++) begin
         sum = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 6)] : 9'($urandom);
         set_req(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 3), sum);
         stall     = ($urandom_range(0, 9) == 0);
         pred_read = ($urandom_range(0, 3) == 0);
         model_expect();
         #1;
         n_checks++;
         if (obs_vec() !== exp_v) begin
            n_errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_v);
         end
         advance();
      end
      set_req(1'b0, 10'd0, 1'b0, 1'b0, 9'd0);
      stall = 1'b0;
      pred_read = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_mispred();
      test_threshold();
      test_fifo_full();
      test_stall();
      test_random();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bfnp_update_scheduler.md
BFNP_UPDATE_SCHEDULER -- requirements
Module: bfnp_update_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: training-request FIFO entries (power of two, >= 2).
REQ-002 Parameter THETA, default 45: training threshold on |sum|, unsigned.
REQ-003 Parameter TBL_ENTRIES, default 1024: entries swept by the initialisation clear.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port stall, input, 1: pipeline stall; freezes request acceptance and update issue.
REQ-007 Port req_valid, input, 1: a resolved branch offers a training request.
REQ-008 Port req_index, input, 10: table index of the resolved branch.
REQ-009 Port req_dir, input, 1: actual branch direction (1 = taken).
REQ-010 Port req_mispred, input, 1: the branch was mispredicted.
REQ-011 Port req_sum, input, 9: signed two's-complement perceptron output for the branch.
REQ-012 Port req_ready, output, 1: the scheduler can accept a request this cycle.
REQ-013 Port pred_read, input, 1: the prediction path owns the table port this cycle.
REQ-014 Port upd_en, output, 1: one-cycle write strobe to the bias, perceptron and BF tables.
REQ-015 Port upd_index, output, 10: write index for upd_en.
REQ-016 Port upd_dir, output, 1: training direction for upd_en.
REQ-017 Port upd_clear, output, 1: the write is a zeroing write issued by the init sweep.
REQ-018 Port init_busy, output, 1: the init sweep is in progress.
REQ-019 Port fifo_count, output, $clog2(DEPTH)+1: number of queued entries.
REQ-020 Port train_count, output, 16: saturating count of training writes issued.

Function
REQ-021 FSM states are INIT, IDLE and ISSUE; reset enters INIT.
REQ-022 INIT: one write per cycle with upd_en=1, upd_clear=1 and upd_index from 0 to TBL_ENTRIES-1, ignoring stall and pred_read; after the last index the FSM goes to IDLE.
REQ-023 In INIT, req_ready=0 and init_busy=1; init_busy falls in the cycle the FSM enters IDLE.
REQ-024 req_ready = (state != INIT) && (fifo_count < DEPTH), with no combinational path from pop.
REQ-025 A request is accepted when req_valid && req_ready && !stall.
REQ-026 An accepted request is enqueued only if req_mispred=1 or |req_sum| <= THETA (the threshold test depends on REQ-039); otherwise it is consumed silently.
REQ-027 |req_sum| is computed in 10 bits, so -256 maps to 256 and never passes the threshold test.
REQ-028 IDLE goes to ISSUE when the FIFO is non-empty.
REQ-029 In ISSUE, in a cycle with !stall && !pred_read: upd_en=1, upd_clear=0, upd_index/upd_dir from the head entry, the head is popped, and train_count increments (saturating at 16'hFFFF).
REQ-030 ISSUE returns to IDLE when the pop empties the FIFO and no push occurs in the same cycle.
REQ-031 Minimum latency from acceptance (cycle N) to upd_en is cycle N+2; entries issue in FIFO order, one per cycle.
REQ-032 Simultaneous push and pop are both performed and fifo_count is unchanged.
REQ-033 When pred_read or stall is high, upd_en=0 and the head entry is held unchanged.
REQ-034 Outside the cycles defined above, upd_en=0 and upd_clear=0.

Reset
REQ-035 On rst low: state=INIT, sweep index=0, FIFO empty, fifo_count=0, train_count=0, upd_en=0, upd_clear=0, req_ready=0, init_busy=1, upd_index=0, upd_dir=0.
REQ-036 Reset asserted mid-sweep or mid-issue discards queued entries, and the sweep restarts from index 0.

Configuration
REQ-037 Macro BFNP_THRESHOLD_TRAIN_EN controls threshold-based training.
REQ-038 Without the macro, only requests with req_mispred=1 are enqueued and req_sum is unused.
REQ-039 With the macro defined, the threshold rule of REQ-026 is active.

Structure
REQ-040 Package bfnp_pkg holds: the state enum, the FIFO entry struct {index[10], dir}, BFNP_IDX_W=10, BFNP_SUM_W=9, and the default THETA.
REQ-041 The FIFO is sub-module bfnp_upd_fifo (push, pop, full, empty, count); the FSM and counters live in the top.

Verification
REQ-042 Release rst: upd_en=upd_clear=1 for exactly 1024 cycles with indices 0..1023, then init_busy=0 and req_ready=1.
REQ-043 Mispredict request with index 0x155 and dir 1 accepted at cycle N, pred_read=0: upd_en=1, upd_index=0x155, upd_dir=1 at N+2; train_count=1.
REQ-044 With the macro defined: req_sum=-45 with mispred=0 is queued, req_sum=46 is dropped, req_sum=-256 is dropped. Without the macro, all three are dropped.
REQ-045 Hold pred_read=1 and push 5 requests: req_ready=0 after 4 pushes, fifo_count=4. Then release pred_read: 4 writes on consecutive cycles in order, then req_ready=1.
REQ-046 Assert rst mid-sweep at index 300 with 2 entries queued: fifo_count=0, and the sweep restarts at index 0 after release.
REQ-047 Stall for 3 cycles with 2 entries queued: upd_en stays 0 and the head is unchanged; after the stall, the 2 writes issue back-to-back.
